shiftout: RTL and testbench



---
 rtl/shiftout_pkg.sv | 12 +
 rtl/shiftout.sv | 101 ++++++++++
 tb/tb_shiftout.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/shiftout_pkg.sv
// Shared definitions for the shiftout serial transmitter and its matching receiver.
package shiftout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int unsigned SHIFTOUT_WIDTH = 8;

endpackage

// File: rtl/shiftout.sv
// Parallel-to-serial transmitter: load a word via valid/ready, emit one bit per enable strobe.
// Define SHIFTOUT_LATCH_EN to add a trailing LATCH phase that drives a register-latch strobe.
module shiftout
  import shiftout_pkg::*;
#(
  parameter int unsigned WIDTH     = SHIFTOUT_WIDTH,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             data,
  output logic             shift_active,
  output logic             done,
  output logic             latch
);

  localparam int unsigned   IW   = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_t           state;
  logic [IW-1:0]    index;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] ordered;
  logic             first_bit;

  // Bit order is folded into a reordered view so the shifter always walks index upward.
  always_comb begin
    ordered = shadow;
    if (MSB_FIRST != 0) ordered = {<<{shadow}};
  end

  assign first_bit  = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
  assign load_ready = (state == IDLE);

`ifdef SHIFTOUT_LATCH_EN
  logic latch_q;
  assign latch = latch_q;
`else
  assign latch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      index        <= '0;
      shadow       <= '0;
      data         <= 1'b0;
      shift_active <= 1'b0;
      done         <= 1'b0;
`ifdef SHIFTOUT_LATCH_EN
      latch_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            shadow       <= load_data;
            index        <= '0;
            data         <= first_bit;
            shift_active <= 1'b1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable) begin
            if (index != LAST) begin
              index <= index + 1'b1;
              data  <= ordered[index + 1'b1];
            end else begin
              data         <= 1'b0;
              shift_active <= 1'b0;
`ifdef SHIFTOUT_LATCH_EN
              latch_q      <= 1'b1;
              state        <= LATCH;
`else
              done         <= 1'b1;
              state        <= IDLE;
`endif
            end
          end
        end
`ifdef SHIFTOUT_LATCH_EN
        LATCH: begin
          if (enable) begin
            latch_q <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftout.sv
// Self-checking bench for shiftout: LSB-first and MSB-first instances, scoreboarded bit stream.
module tb_shiftout;
  import shiftout_pkg::*;

  localparam int W = SHIFTOUT_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         en_a, lv_a, lr_a, data_a, sa_a, done_a, latch_a;
  logic [W-1:0] ld_a;
  logic         en_b, lv_b, lr_b, data_b, sa_b, done_b, latch_b;
  logic [W-1:0] ld_b;

  shiftout #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .enable(en_a), .load_valid(lv_a), .load_data(ld_a),
    .load_ready(lr_a), .data(data_a), .shift_active(sa_a), .done(done_a), .latch(latch_a)
  );

  shiftout #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .enable(en_b), .load_valid(lv_b), .load_data(ld_b),
    .load_ready(lr_b), .data(data_b), .shift_active(sa_b), .done(done_b), .latch(latch_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ndone_a  = 0;
  int ndone_b  = 0;
  logic [W-1:0] rx;
  logic exp_q[$];

  always @(negedge clk) begin
    if (done_a) ndone_a++;
    if (done_b) ndone_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_bit(output logic b);
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'd1, 32'd0);
      b = 1'b0;
    end else begin
      b = exp_q.pop_front();
    end
  endtask

  // One LSB-first frame; optional mid-frame offer of hold_w and optional reset after abort_at enables.
  task automatic send_a(input logic [W-1:0] w, input int gap, input logic hold,
                        input logic [W-1:0] hold_w, input int abort_at);
    int   d0;
    logic b;
    lv_a = 1'b1;
    ld_a = w;
    en_a = 1'b1;
    check("ready_before_accept", 32'(lr_a), 32'd1);
    for (int i = 0; i < W; i++) exp_q.push_back(w[i]);
    tick();
    lv_a = hold;
    ld_a = hold_w;
    en_a = 1'b0;
    check("done_one_cycle", 32'(done_a), 32'd0);
    check("active_after_accept", 32'(sa_a), 32'd1);
    check("ready_in_shift", 32'(lr_a), 32'd0);
    d0 = ndone_a;
    for (int k = 1; k <= W; k++) begin
      for (int g = 1; g < gap; g++) tick();
      en_a = 1'b1;
      pop_bit(b);
      check("bit_a", 32'(data_a), 32'(b));
      check("ready_mid_frame", 32'(lr_a), 32'd0);
      rx = {data_a, rx[W-1:1]};
      tick();
      en_a = 1'b0;
      if (k == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_data", 32'(data_a), 32'd0);
        check("abort_active", 32'(sa_a), 32'd0);
        check("abort_ready", 32'(lr_a), 32'd1);
        check("abort_latch", 32'(latch_a), 32'd0);
        exp_q.delete();
        tick();
        check("abort_no_done", 32'(ndone_a - d0), 32'd0);
        return;
      end
    end
    check("no_early_done", 32'(ndone_a - d0), 32'd0);
`ifdef SHIFTOUT_LATCH_EN
    check("latch_rise", 32'(latch_a), 32'd1);
    check("latch_no_done", 32'(done_a), 32'd0);
    check("latch_data", 32'(data_a), 32'd0);
    check("latch_active", 32'(sa_a), 32'd0);
    check("latch_ready", 32'(lr_a), 32'd0);
    tick();
    check("latch_hold", 32'(latch_a), 32'd1);
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    check("latch_fall", 32'(latch_a), 32'd0);
`else
    check("latch_tied", 32'(latch_a), 32'd0);
`endif
    check("done_pulse", 32'(done_a), 32'd1);
    check("idle_data", 32'(data_a), 32'd0);
    check("idle_active", 32'(sa_a), 32'd0);
    check("ready_back", 32'(lr_a), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic b;
    int   cyc;
    reset = 1'b1;
    en_a = 1'b0; lv_a = 1'b0; ld_a = '0;
    en_b = 1'b0; lv_b = 1'b0; ld_b = '0;
    rx = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_active", 32'(sa_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_latch", 32'(latch_a), 32'd0);
    check("rst_ready", 32'(lr_a), 32'd1);
    check("rst_ready_b", 32'(lr_b), 32'd1);

    // Enable every 4th cycle.
    send_a(8'hA5, 4, 1'b0, '0, 0);

    // Loopback into a receiver shifting on the same enable.
    rx = '0;
    send_a(8'h3C, 1, 1'b0, '0, 0);
    check("rx_frame1", 32'(rx), 32'h3C);
    rx = '0;
    send_a(8'hC3, 2, 1'b0, '0, 0);
    check("rx_frame2", 32'(rx), 32'hC3);

    // A word offered throughout the frame waits until the first IDLE cycle.
    send_a(8'h00, 1, 1'b1, 8'hFF, 0);
    rx = '0;
    send_a(8'hFF, 1, 1'b0, '0, 0);
    check("rx_ff", 32'(rx), 32'hFF);

    // Reset after the 3rd enable abandons the frame.
    send_a(8'h5A, 2, 1'b0, '0, 3);

    send_a(8'h01, 3, 1'b0, '0, 0);

    // MSB-first instance with enable held high, including through the accept cycle.
    lv_b = 1'b1;
    ld_b = 8'h80;
    en_b = 1'b1;
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(ld_b[i]);
    tick();
    lv_b = 1'b0;
    ld_b = 8'h7F;
    check("msb_active", 32'(sa_b), 32'd1);
    cyc = 0;
    for (int k = 0; k < W; k++) begin
      pop_bit(b);
      check("bit_b", 32'(data_b), 32'(b));
      tick();
      cyc++;
    end
`ifdef SHIFTOUT_LATCH_EN
    check("msb_latch", 32'(latch_b), 32'd1);
    tick();
    cyc++;
`endif
    en_b = 1'b0;
    check("msb_done", 32'(done_b), 32'd1);
    check("msb_done_cycles", 32'(cyc), 32'(W + ((latch_b === 1'b0 && done_b === 1'b1 && cyc > W) ? 1 : 0)));
    tick();
    check("msb_done_count", 32'(ndone_b), 32'd1);
    check("msb_ready", 32'(lr_b), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
